// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   - arb_state_t : arbitration FSM state encoding
//   - REQ_CPU / REQ_LOADER : requester index constants
//   - LOCK_MAX_DEF : default bound on consecutive locked grants
//   - own_state() : maps a requester index to its ownership state
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST  = 2'd0,
    OWN0_ST = 2'd1,
    OWN1_ST = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int LOCK_MAX_DEF = 4;

  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN1_ST : OWN0_ST;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// Ports:
//   req0, req1 : request lines
//   last       : index of the most recent winner
//   idx        : chosen requester (meaningful only when valid=1)
//   valid      : at least one request present
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic idx,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    // On a tie the requester that did not win last time goes next;
    // otherwise whichever one is asking (req1 alone -> 1, else 0).
    if (req0 && req1) begin
      idx = ~last;
    end else begin
      idx = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous-read memory.
// Requester 0 is the CPU fetch/operand path, requester 1 the loader/debug
// path. Round-robin between them, with a bounded lock so a requester can
// keep ownership for up to LOCK_MAX consecutive accesses.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   reqN/weN/lockN/addrN/wdataN         : requester N access request + qualifiers
//   gntN                                : access for N issued this cycle
//   rvalidN/rdataN                      : read data for N, one cycle after grant
//   mem_addr/mem_we/mem_wdata/mem_rdata : memory port (1-cycle read latency)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  // Count value at which the next locked grant is the last one allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t        state_reg, state_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic [1:0]        rvalid_reg;

  logic [1:0]        req_vec, we_vec, lock_vec, gnt_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [DATA_W-1:0] wdata_vec [2];
  logic [DATA_W-1:0] rdata_vec [2];

  logic pick_idx, pick_valid;
  logic own_idx;
  logic win_idx;
  logic gnt_any;

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign lock_vec     = {lock1, lock0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_idx = (state_reg == OWN1_ST) ? REQ_LOADER : REQ_CPU;

  // Next-state and grant logic.
  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    lock_cnt_next = lock_cnt_reg;
    gnt_vec       = 2'b00;
    win_idx       = pick_idx;

    case (state_reg)
      ARB_ST: begin
        win_idx = pick_idx;
        if (pick_valid) begin
          gnt_vec[pick_idx] = 1'b1;
          last_next         = pick_idx;
          // A bound of one grant leaves nothing to hold on to.
          if (lock_vec[pick_idx] && (LOCK_MAX > 1)) begin
            state_next    = own_state(pick_idx);
            lock_cnt_next = CNT_W'(1);
          end
        end
      end

      OWN0_ST, OWN1_ST: begin
        win_idx = own_idx;
        if (req_vec[own_idx]) begin
          gnt_vec[own_idx] = 1'b1;
          last_next        = own_idx;
          // Dropping lock and hitting the bound both hand back to ARB;
          // last stays with the owner so a waiting peer wins next.
          if (!lock_vec[own_idx] || (lock_cnt_reg >= CNT_LAST)) begin
            state_next    = ARB_ST;
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt_reg + CNT_W'(1);
          end
        end else begin
          // Owner went quiet: give up ownership, no grant this cycle.
          state_next    = ARB_ST;
          lock_cnt_next = '0;
        end
      end

      default: begin
        state_next    = ARB_ST;
        lock_cnt_next = '0;
      end
    endcase
  end

  assign gnt_any = |gnt_vec;
  assign gnt0    = gnt_vec[0];
  assign gnt1    = gnt_vec[1];

  // Memory port: winner's access in a grant cycle; address/data hold
  // their last values while idle so the memory sees a stable bus.
  assign mem_addr  = gnt_any ? addr_vec[win_idx]  : addr_hold_reg;
  assign mem_wdata = gnt_any ? wdata_vec[win_idx] : wdata_hold_reg;
  assign mem_we    = gnt_any & we_vec[win_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ARB_ST;
      last_reg       <= REQ_LOADER;
      lock_cnt_reg   <= '0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      rvalid_reg     <= 2'b00;
    end else begin
      state_reg      <= state_next;
      last_reg       <= last_next;
      lock_cnt_reg   <= lock_cnt_next;
      addr_hold_reg  <= mem_addr;
      wdata_hold_reg <= mem_wdata;
      rvalid_reg     <= gnt_vec & ~we_vec;
    end
  end

  // Read data is only forwarded to the requester that issued the read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    assign rdata_vec[gi] = rvalid_reg[gi] ? mem_rdata : '0;
  end

  assign rvalid0 = rvalid_reg[0];
  assign rvalid1 = rvalid_reg[1];
  assign rdata0  = rdata_vec[0];
  assign rdata1  = rdata_vec[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random
// traffic. The stimulus process runs a transaction-level reference model
// and queues expected per-cycle bus activity and read returns; a separate
// monitor process compares them against the DUT at each falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [7:0]  addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0]  rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // External memory: synchronous write, 1-cycle registered read.
  logic [7:0] mem [256];
  logic       preload;

  function automatic logic [7:0] init_val(input int i);
    return (i == 5) ? 8'hAB : 8'(i * 37 + 11);
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[8'(i)] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    bit         req;
    bit         we;
    bit         lock;
    logic [7:0] addr;
    logic [7:0] wdata;
  } rq_t;

  typedef struct {
    int         cyc;
    bit         skip;
    logic [1:0] gnt;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q0[$];
  rd_t  rd_q1[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Reference model state: who owns the memory (-1 = nobody), how many
  // grants the owner has had under lock, and who won most recently.
  rq_t        cur [2];
  logic [7:0] ref_mem [256];
  int         owner;
  int         run;
  bit         last;
  logic [7:0] hold_addr, hold_wdata;
  int         cyc = 0;
  int         mgnt;

  task automatic step(input bit rst);
    exp_t e;
    rd_t  r;
    int   w;
    bit   wi;
    @(posedge clk);
    #1;
    cyc++;
    reset  = rst;
    req0   = cur[0].req; we0 = cur[0].we; lock0 = cur[0].lock;
    addr0  = cur[0].addr; wdata0 = cur[0].wdata;
    req1   = cur[1].req; we1 = cur[1].we; lock1 = cur[1].lock;
    addr1  = cur[1].addr; wdata1 = cur[1].wdata;

    e.cyc = cyc; e.skip = rst; e.gnt = 2'b00; e.we = 1'b0;
    e.addr = 8'h00; e.wdata = 8'h00;
    w = -1;
    if (rst) begin
      owner = -1; run = 0; last = 1'b1;
      hold_addr = 8'h00; hold_wdata = 8'h00;
      rd_q0.delete(); rd_q1.delete();
    end else begin
      if (owner >= 0) begin
        wi = owner[0];
        if (cur[wi].req) begin
          w = owner;
          run++;
          if (!cur[wi].lock || run >= LOCK_MAX) owner = -1;
        end else begin
          owner = -1;
        end
      end else begin
        if (cur[0].req && cur[1].req) w = last ? 0 : 1;
        else if (cur[0].req)          w = 0;
        else if (cur[1].req)          w = 1;
        if (w >= 0) begin
          wi = w[0];
          if (cur[wi].lock && LOCK_MAX > 1) begin
            owner = w;
            run   = 1;
          end
        end
      end
      if (w >= 0) begin
        wi         = w[0];
        last       = wi;
        hold_addr  = cur[wi].addr;
        hold_wdata = cur[wi].wdata;
        e.gnt[wi]  = 1'b1;
        e.we       = cur[wi].we;
        if (cur[wi].we) begin
          ref_mem[cur[wi].addr] = cur[wi].wdata;
        end else begin
          r.due  = cyc + 1;
          r.data = ref_mem[cur[wi].addr];
          if (wi) rd_q1.push_back(r);
          else    rd_q0.push_back(r);
        end
      end
      e.addr  = hold_addr;
      e.wdata = hold_wdata;
    end
    mgnt = w;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic retire();
    if (mgnt == 0) cur[0].req = 1'b0;
    if (mgnt == 1) cur[1].req = 1'b0;
  endtask

  task automatic set_req(input bit n, input bit we, input bit lock,
                         input logic [7:0] addr, input logic [7:0] wdata);
    cur[n].req = 1'b1; cur[n].we = we; cur[n].lock = lock;
    cur[n].addr = addr; cur[n].wdata = wdata;
  endtask

  task automatic new_req(input bit n);
    if (!cur[n].req && $urandom_range(0, 9) < 6) begin
      cur[n].req   = 1'b1;
      cur[n].we    = n ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
      cur[n].lock  = n ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      cur[n].addr  = 8'($urandom_range(0, 15));
      cur[n].wdata = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    cur[0].req = 1'b0;
    cur[1].req = 1'b0;
    step(1'b1);
  endtask

  // Monitor: one expectation per cycle; read returns matched by due cycle.
  initial begin
    exp_t e;
    bit   ev;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.skip) begin
          chk("gnt", 32'({gnt1, gnt0}), 32'(e.gnt));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));

          ev = (rd_q0.size() != 0) && (rd_q0[0].due == e.cyc);
          chk("rvalid0", 32'(rvalid0), 32'(ev));
          if (ev) begin
            if (rvalid0) chk("rdata0", 32'(rdata0), 32'(rd_q0[0].data));
            void'(rd_q0.pop_front());
          end else if (!rvalid0) begin
            chk("rdata0_idle", 32'(rdata0), 32'h0);
          end

          ev = (rd_q1.size() != 0) && (rd_q1[0].due == e.cyc);
          chk("rvalid1", 32'(rvalid1), 32'(ev));
          if (ev) begin
            if (rvalid1) chk("rdata1", 32'(rdata1), 32'(rd_q1[0].data));
            void'(rd_q1.pop_front());
          end else if (!rvalid1) begin
            chk("rdata1_idle", 32'(rdata1), 32'h0);
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] seq4 [10];
    reset = 1'b1; preload = 1'b1;
    req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[8'(i)] = init_val(i);
    for (int n = 0; n < 2; n++) cur[n] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    owner = -1; run = 0; last = 1'b1; hold_addr = 8'h00; hold_wdata = 8'h00;
    mgnt = -1;

    do_reset();
    preload = 1'b0;

    // Reset state, then a single read of address 5.
    step(1'b0);
    chk("reset_gnt", 32'({gnt1, gnt0}), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_rvalid0", 32'(rvalid0), 32'h0);
    chk("reset_rdata0", 32'(rdata0), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
    step(1'b0); retire();
    chk("single_gnt", 32'({gnt1, gnt0}), 32'h1);
    step(1'b0);
    chk("single_rvalid0", 32'(rvalid0), 32'h1);
    chk("single_rdata0", 32'(rdata0), 32'hAB);
    chk("single_rvalid1", 32'(rvalid1), 32'h0);

    // Tie round-robin without lock.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(1'b0, 1'b0, 1'b0, 8'(i), 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 8'h00);
      step(1'b0);
      chk("tie_rr", 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // CPU fetch lock over three bytes with the loader waiting.
    do_reset();
    set_req(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_req(1'b0, 1'b0, (i < 2), 8'(i), 8'h00);
      else       cur[0].req = 1'b0;
      step(1'b0); retire();
      chk("fetch_lock", 32'({gnt1, gnt0}), (i < 3) ? 32'h1 : 32'h2);
    end

    // Lock bound with both requesters continuous.
    do_reset();
    seq4 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 10; i++) begin
      set_req(1'b0, 1'b0, 1'b1, 8'(i), 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 8'h00);
      step(1'b0);
      chk("lock_bound", 32'({gnt1, gnt0}), 32'(seq4[i]));
    end

    // Loader write then CPU read of the same address.
    do_reset();
    set_req(1'b0, 1'b0, 1'b0, 8'h11, 8'h00);
    step(1'b0); retire();
    set_req(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A);
    step(1'b0); retire();
    chk("wr_gnt", 32'({gnt1, gnt0}), 32'h2);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    step(1'b0); retire();
    chk("rd_after_wr_gnt", 32'({gnt1, gnt0}), 32'h1);
    chk("rd_after_wr_mem_we", 32'(mem_we), 32'h0);
    chk("wr_no_rvalid1", 32'(rvalid1), 32'h0);
    step(1'b0);
    chk("rd_after_wr_rvalid0", 32'(rvalid0), 32'h1);
    chk("rd_after_wr_rdata0", 32'(rdata0), 32'h5A);

    // Reset while owning with a read in flight.
    do_reset();
    set_req(1'b0, 1'b0, 1'b1, 8'h05, 8'h00);
    step(1'b0);
    chk("pre_reset_gnt", 32'({gnt1, gnt0}), 32'h1);
    set_req(1'b0, 1'b0, 1'b1, 8'h06, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h07, 8'h00);
    step(1'b1);
    cur[0].lock = 1'b0;
    step(1'b0); retire();
    chk("post_reset_rvalid0", 32'(rvalid0), 32'h0);
    chk("post_reset_tie", 32'({gnt1, gnt0}), 32'h1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      new_req(1'b0);
      new_req(1'b1);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(1'b0);
        retire();
      end
    end

    cur[0].req = 1'b0;
    cur[1].req = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("rd_queues_drained", 32'(rd_q0.size() + rd_q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
